// File: rtl/jk_stim_checker_if.sv
// -----------------------------------------------------------------------------
// jk_stim_checker_if
// Groups the signals between the JK stimulus/checker and its surroundings:
// the stimulus bus to the JK device under test and the run control/status.
//
//   start    run request, level-sampled on clk
//   q        flip-flop output returned by the JK device under test
//   j, k     J/K stimulus to the device
//   clock    divided stimulus clock; the device samples j,k on its rising edge
//   busy     run in progress
//   done     run complete, results valid
//   pass     done with zero mismatches
//   err_cnt  saturating mismatch count
//   vec_idx  index of the current or last applied vector
//
// master: the checker.  slave: the environment (device + controller).
// -----------------------------------------------------------------------------
interface jk_stim_checker_if;
   logic       start;
   logic       q;
   logic       j;
   logic       k;
   logic       clock;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_cnt;
   logic [7:0] vec_idx;

   modport master (
      input  start, q,
      output j, k, clock, busy, done, pass, err_cnt, vec_idx
   );

   modport slave (
      output start, q,
      input  j, k, clock, busy, done, pass, err_cnt, vec_idx
   );
endinterface

// File: rtl/jk_stim_checker.sv
// -----------------------------------------------------------------------------
// jk_stim_checker
// Drives a JK flip-flop with a fixed cycle of J/K vectors on a divided stimulus
// clock, predicts the flip-flop output and counts mismatches against q.
// Each vector takes 2*DIV clk cycles: DIV with clock low (SETUP), then DIV
// with clock high (HIGH). q is compared on the last HIGH cycle only.
//
// Ports:
//   clk    system clock, sole clock of the block
//   rst_n  synchronous active-low reset
//   bus    jk_stim_checker_if.master (start, q in; j, k, clock, busy, done,
//          pass, err_cnt, vec_idx out; all outputs registered)
//
// Parameters:
//   DIV    clk cycles per stimulus clock phase, 2..2^27-1
//   NVEC   vectors applied per run, 1..255
// -----------------------------------------------------------------------------
module jk_stim_checker #(
   parameter int unsigned DIV  = 20000000,
   parameter int unsigned NVEC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   jk_stim_checker_if.master bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] HIGH  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [26:0] PHASE_LAST = 27'(DIV - 1);
   localparam logic [7:0]  VEC_LAST   = 8'(NVEC - 1);

   logic [1:0]  state;
   logic [26:0] phase;
   logic        exp_q;
   logic        j_r;
   logic        k_r;
   logic        clock_r;
   logic        busy_r;
   logic        done_r;
   logic        pass_r;
   logic [7:0]  err_cnt_r;
   logic [7:0]  vec_idx_r;
   logic        mismatch;

   // Vector order 01,10,00,11: the first vector always resets the device.
   function automatic logic [1:0] pattern(input logic [1:0] idx);
      case (idx)
         2'd0:    return 2'b01;
         2'd1:    return 2'b10;
         2'd2:    return 2'b00;
         default: return 2'b11;
      endcase
   endfunction

   // JK characteristic: 00 hold, 01 reset, 10 set, 11 toggle.
   function automatic logic jk_next(input logic cur, input logic jv, input logic kv);
      return (jv & ~cur) | (~kv & cur);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Only consumed on the compare cycle, so q has no effect at other times.
   assign mismatch = bus.q ^ exp_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         phase     <= '0;
         exp_q     <= 1'b0;
         j_r       <= 1'b0;
         k_r       <= 1'b0;
         clock_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         pass_r    <= 1'b0;
         err_cnt_r <= '0;
         vec_idx_r <= '0;
      end else begin
         case (state)
            // DONE holds its results until a new start, which behaves as from IDLE.
            IDLE, DONE: begin
               if (bus.start) begin
                  state        <= SETUP;
                  phase        <= '0;
                  exp_q        <= 1'b0;
                  err_cnt_r    <= '0;
                  vec_idx_r    <= '0;
                  {j_r, k_r}   <= pattern(2'd0);
                  clock_r      <= 1'b0;
                  busy_r       <= 1'b1;
                  done_r       <= 1'b0;
                  pass_r       <= 1'b0;
               end
            end
            SETUP: begin
               if (phase == PHASE_LAST) begin
                  state   <= HIGH;
                  phase   <= '0;
                  clock_r <= 1'b1;
                  // Device captures j,k on this rising edge; predict its new state.
                  exp_q   <= jk_next(exp_q, j_r, k_r);
               end else begin
                  phase <= phase + 27'd1;
               end
            end
            HIGH: begin
               if (phase == PHASE_LAST) begin
                  phase   <= '0;
                  clock_r <= 1'b0;
                  if (mismatch)
                     err_cnt_r <= sat_inc(err_cnt_r);
                  if (vec_idx_r == VEC_LAST) begin
                     state  <= DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     // Include this final comparison in the verdict.
                     pass_r <= (err_cnt_r == 8'd0) && !mismatch;
                     j_r    <= 1'b0;
                     k_r    <= 1'b0;
                  end else begin
                     state      <= SETUP;
                     vec_idx_r  <= vec_idx_r + 8'd1;
                     {j_r, k_r} <= pattern(vec_idx_r[1:0] + 2'd1);
                  end
               end else begin
                  phase <= phase + 27'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.j       = j_r;
   assign bus.k       = k_r;
   assign bus.clock   = clock_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.pass    = pass_r;
   assign bus.err_cnt = err_cnt_r;
   assign bus.vec_idx = vec_idx_r;

endmodule

// File: tb/tb_jk_stim_checker.sv
// -----------------------------------------------------------------------------
// tb_jk_stim_checker
// Directed bench for jk_stim_checker with three instances:
//   u_a  DIV=4, NVEC=8    ideal / stuck-at-0 device, reset mid-run, held start
//   u_b  DIV=2, NVEC=8    ideal device, minimum divider
//   u_c  DIV=2, NVEC=255  inverted device, every compare mismatches
// Each instance has a behavioural JK flip-flop clocked by its stimulus clock.
// -----------------------------------------------------------------------------
module tb_jk_stim_checker;

   logic clk;
   logic rst_n;

   jk_stim_checker_if ifa ();
   jk_stim_checker_if ifb ();
   jk_stim_checker_if ifc ();

   jk_stim_checker #(.DIV(4), .NVEC(8))   u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   jk_stim_checker #(.DIV(2), .NVEC(8))   u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   jk_stim_checker #(.DIV(2), .NVEC(255)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Device models: 0 = ideal, 1 = stuck at 0, 2 = inverted ideal.
   int   mode_a;
   logic qa_m = 1'b0;
   logic qb_m = 1'b0;
   logic qc_m = 1'b0;

   function automatic logic jk_ff(input logic cur, input logic jv, input logic kv);
      case ({jv, kv})
         2'b00:   return cur;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~cur;
      endcase
   endfunction

   always @(posedge ifa.clock) qa_m <= jk_ff(qa_m, ifa.j, ifa.k);
   always @(posedge ifb.clock) qb_m <= jk_ff(qb_m, ifb.j, ifb.k);
   always @(posedge ifc.clock) qc_m <= jk_ff(qc_m, ifc.j, ifc.k);

   assign ifa.q = (mode_a == 1) ? 1'b0 : qa_m;
   assign ifb.q = qb_m;
   assign ifc.q = ~qc_m;

   int total;
   int bad;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hand-derived tables: vector pattern {j,k}, and cumulative error count
   // after each vector with a stuck-at-0 device (expected q 0,1,1,0,0,1,1,0).
   logic [1:0] pat  [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
   logic [7:0] errs [8] = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd4, 8'd4};

   initial begin
      total     = 0;
      bad       = 0;
      mode_a    = 0;
      rst_n     = 1'b0;
      ifa.start = 1'b1;   // start must be ignored while in reset
      ifb.start = 1'b0;
      ifc.start = 1'b0;

      // ---------------- reset state ----------------
      step(3);
      chk("rst_busy",  32'(ifa.busy),    0);
      chk("rst_done",  32'(ifa.done),    0);
      chk("rst_pass",  32'(ifa.pass),    0);
      chk("rst_clock", 32'(ifa.clock),   0);
      chk("rst_jk",    32'({ifa.j, ifa.k}), 0);
      chk("rst_err",   32'(ifa.err_cnt), 0);
      chk("rst_vec",   32'(ifa.vec_idx), 0);

      // ---------------- ideal run, first edge out of reset starts it ----------------
      rst_n = 1'b1;
      step(1);
      ifa.start = 1'b0;
      chk("a_busy_rise", 32'(ifa.busy), 1);
      for (int v = 0; v < 8; v++) begin
         chk("a_setup_clock", 32'(ifa.clock), 0);
         chk("a_setup_jk",    32'({ifa.j, ifa.k}), 32'(pat[2'(v)]));
         chk("a_setup_vec",   32'(ifa.vec_idx), v);
         chk("a_setup_busy",  32'(ifa.busy), 1);
         if (v == 3) ifa.start = 1'b1;   // mid-run start pulse is ignored
         step(4);
         ifa.start = 1'b0;
         chk("a_high_clock", 32'(ifa.clock), 1);
         chk("a_high_jk",    32'({ifa.j, ifa.k}), 32'(pat[2'(v)]));
         step(3);
         if (v == 7) chk("a_done_early", 32'(ifa.done), 0);
         step(1);
      end
      chk("a_done",      32'(ifa.done),    1);
      chk("a_busy_fall", 32'(ifa.busy),    0);
      chk("a_pass",      32'(ifa.pass),    1);
      chk("a_err",       32'(ifa.err_cnt), 0);
      chk("a_vec",       32'(ifa.vec_idx), 7);
      chk("a_done_jk",   32'({ifa.j, ifa.k, ifa.clock}), 0);
      step(5);
      chk("a_done_held", 32'(ifa.done), 1);

      // ---------------- stuck-at-0 device, restart from DONE ----------------
      mode_a    = 1;
      ifa.start = 1'b1;
      step(1);
      ifa.start = 1'b0;
      chk("s_restart_done", 32'(ifa.done), 0);
      chk("s_restart_busy", 32'(ifa.busy), 1);
      for (int v = 0; v < 8; v++) begin
         step(8);
         chk("s_err_step", 32'(ifa.err_cnt), 32'(errs[3'(v)]));
      end
      chk("s_done", 32'(ifa.done),    1);
      chk("s_pass", 32'(ifa.pass),    0);
      chk("s_err",  32'(ifa.err_cnt), 4);
      chk("s_vec",  32'(ifa.vec_idx), 7);

      // ---------------- reset during HIGH of vector 3 ----------------
      ifa.start = 1'b1;
      step(1);
      ifa.start = 1'b0;
      step(29);
      chk("r_pre_clock", 32'(ifa.clock),   1);
      chk("r_pre_vec",   32'(ifa.vec_idx), 3);
      chk("r_pre_err",   32'(ifa.err_cnt), 2);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      chk("r_busy",  32'(ifa.busy),    0);
      chk("r_clock", 32'(ifa.clock),   0);
      chk("r_jk",    32'({ifa.j, ifa.k}), 0);
      chk("r_err",   32'(ifa.err_cnt), 0);
      chk("r_vec",   32'(ifa.vec_idx), 0);
      chk("r_done",  32'(ifa.done),    0);
      step(10);
      chk("r_idle_busy", 32'(ifa.busy), 0);

      // ---------------- start held high: back-to-back runs ----------------
      mode_a    = 0;
      ifa.start = 1'b1;
      step(1);
      chk("h_busy", 32'(ifa.busy), 1);
      step(64);
      chk("h_done1",      32'(ifa.done), 1);
      chk("h_done1_busy", 32'(ifa.busy), 0);
      step(1);
      chk("h_done_pulse", 32'(ifa.done), 0);
      chk("h_busy2",      32'(ifa.busy), 1);
      ifa.start = 1'b0;
      step(64);
      chk("h_done2", 32'(ifa.done), 1);
      chk("h_pass2", 32'(ifa.pass), 1);

      // ---------------- DIV=2 boundary ----------------
      ifb.start = 1'b1;
      step(1);
      ifb.start = 1'b0;
      for (int c = 0; c < 32; c++) begin
         chk("b_clock", 32'(ifb.clock), 32'((c >> 1) & 1));
         chk("b_jk",    32'({ifb.j, ifb.k}), 32'(pat[2'(c >> 2)]));
         step(1);
      end
      chk("b_done", 32'(ifb.done),    1);
      chk("b_pass", 32'(ifb.pass),    1);
      chk("b_err",  32'(ifb.err_cnt), 0);
      chk("b_vec",  32'(ifb.vec_idx), 7);

      // ---------------- NVEC=255, inverted device ----------------
      ifc.start = 1'b1;
      step(1);
      ifc.start = 1'b0;
      step(512);
      chk("c_mid_err",  32'(ifc.err_cnt), 128);
      chk("c_mid_busy", 32'(ifc.busy),    1);
      step(508);
      chk("c_done", 32'(ifc.done),    1);
      chk("c_err",  32'(ifc.err_cnt), 255);
      chk("c_pass", 32'(ifc.pass),    0);
      chk("c_vec",  32'(ifc.vec_idx), 254);
      step(4);
      chk("c_err_held", 32'(ifc.err_cnt), 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
